roic_word_aligner: RTL

Downstream of the single-lane ROIC deserializer. Takes the raw 24-bit frame-rate word, whose bit boundary is arbitrary after ISERDES capture, and finds the correct bit rotation by matching a known training pattern across all WORD_SIZE offsets. After the match holds for enough consecutive frames, it locks that offset and streams aligned pixel words with a valid flag. It also monitors the training pattern for loss of lock.

---
 rtl/roic_word_aligner.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/roic_word_aligner.sv
// Bit-rotation word aligner for the single-lane ROIC deserializer: locks onto TRAIN_PATTERN and streams aligned words.
// Optional feature macro: ROIC_ALIGN_ERR_CNT_EN enables the saturating training-error counter (err_count).
module roic_word_aligner #(
  parameter int                   WORD_SIZE     = 24,
  parameter logic [WORD_SIZE-1:0] TRAIN_PATTERN = 24'hFC0A53,
  parameter int                   LOCK_COUNT    = 4,
  parameter int                   UNLOCK_COUNT  = 3,
  localparam int                  OFS_W         = $clog2(WORD_SIZE)
) (
  input  logic                 fclk_out,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 train_en,
  input  logic                 realign,
  output logic [WORD_SIZE-1:0] word_out,
  output logic                 word_valid,
  output logic                 locked,
  output logic [OFS_W-1:0]     bit_offset,
  output logic [15:0]          err_count
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

  state_t                    state, state_nxt;
  logic [WORD_SIZE-1:0]      d_p0, d_p1;
  // Bit 0 of the two-word window is never part of any candidate, so it is not carried.
  logic [2*WORD_SIZE-1:1]    window;
  logic [WORD_SIZE-1:0]      cand_sel, cand_out;
  logic                      match_any, sel_match, train_miss;
  logic [OFS_W-1:0]          first_k, ofs_nxt;
  logic [3:0]                cnt, cnt_nxt, miss_cnt, miss_nxt;

  assign window     = {d_p1, d_p0[WORD_SIZE-1:1]};
  assign sel_match  = (cand_sel == TRAIN_PATTERN);
  assign train_miss = train_en && !sel_match;
  assign locked     = (state == LOCKED);
  assign word_valid = locked;

  // Pattern scan over all rotations; descending loop leaves the lowest matching k.
  always_comb begin
    match_any = 1'b0;
    first_k   = '0;
    cand_sel  = '0;
    for (int k = WORD_SIZE-1; k >= 0; k--) begin
      if (window[2*WORD_SIZE-1-k -: WORD_SIZE] == TRAIN_PATTERN) begin
        match_any = 1'b1;
        first_k   = OFS_W'(k);
      end
      if (bit_offset == OFS_W'(k)) cand_sel = window[2*WORD_SIZE-1-k -: WORD_SIZE];
    end
  end

  // Output word uses the offset in force after this edge, so a direct SEARCH->LOCKED entry is aligned too.
  always_comb begin
    cand_out = '0;
    for (int k = 0; k < WORD_SIZE; k++) begin
      if (ofs_nxt == OFS_W'(k)) cand_out = window[2*WORD_SIZE-1-k -: WORD_SIZE];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    miss_nxt  = miss_cnt;
    ofs_nxt   = bit_offset;
    if (realign) begin
      state_nxt = SEARCH;
      cnt_nxt   = '0;
      miss_nxt  = '0;
    end else begin
      case (state)
        SEARCH: begin
          if (train_en && match_any) begin
            ofs_nxt = first_k;
            if (LOCK_N == 4'd1) begin
              state_nxt = LOCKED;
              cnt_nxt   = '0;
            end else begin
              state_nxt = VERIFY;
              cnt_nxt   = 4'd1;
            end
          end
        end
        VERIFY: begin
          if (train_en && sel_match) begin
            if (cnt + 4'd1 == LOCK_N) begin
              state_nxt = LOCKED;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end else begin
            state_nxt = SEARCH;
            cnt_nxt   = '0;
          end
        end
        LOCKED: begin
          if (train_miss) begin
            if (miss_cnt + 4'd1 == UNLOCK_N) begin
              state_nxt = SEARCH;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss_cnt + 4'd1;
            end
          end else begin
            miss_nxt = '0;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge fclk_out) begin
    if (rst) state <= SEARCH;
    else     state <= state_nxt;
  end

  always_ff @(posedge fclk_out) begin
    if (rst) begin
      d_p0       <= '0;
      d_p1       <= '0;
      cnt        <= '0;
      miss_cnt   <= '0;
      bit_offset <= '0;
      word_out   <= '0;
    end else begin
      // Stage p0 -> p1: two-word deserializer history
      d_p0       <= data_in;
      d_p1       <= d_p0;
      cnt        <= cnt_nxt;
      miss_cnt   <= miss_nxt;
      bit_offset <= ofs_nxt;
      // Output stage: only refreshed while in (or entering) LOCKED
      if (state_nxt == LOCKED) word_out <= cand_out;
    end
  end

`ifdef ROIC_ALIGN_ERR_CNT_EN
  logic        err_inc;
  logic [15:0] err_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign err_inc = (state == LOCKED) && !realign && train_miss;

  always_ff @(posedge fclk_out) begin
    if (rst)          err_q <= '0;
    else if (err_inc) err_q <= sat_inc16(err_q);
  end

  assign err_count = err_q;
`else
  assign err_count = 16'h0;
`endif

endmodule
